// File: rtl/bist_addr_mux.sv
// bist_addr_mux: registered SRAM address source for the BIST path.
// It combines an up/down BIST sweep counter with the functional/test address select.
// Optional macro BIST_ADDR_COMPL_EN adds the addr_compl input. When that input is set
// in test mode, addr_out carries the bitwise complement of the sweep counter.
module bist_addr_mux #(
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              test_mode,
    input  logic [ADDR_W-1:0] func_addr,
    input  logic              start,
    input  logic              dir,
    input  logic              step,
`ifdef BIST_ADDR_COMPL_EN
    input  logic              addr_compl,
`endif
    output logic [ADDR_W-1:0] addr_out,
    output logic              busy,
    output logic              last,
    output logic              done
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_MIN = '0;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              at_final;

    // The final address depends on the latched direction. An ascending sweep ends at the top address.
    assign at_final = dir_q ? (cnt_q == ADDR_MIN) : (cnt_q == ADDR_MAX);

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state logic: load on start in IDLE, then step toward the final address with no wrap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = dir ? ADDR_MAX : ADDR_MIN;
                    dir_d   = dir;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                if (step) begin
                    if (at_final) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (dir_q) begin
                        cnt_d = cnt_q - ADDR_W'(1);
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Address select is independent of the FSM. test_mode only steers the output.
    always_comb begin
        addr_d = func_addr;
        if (test_mode) begin
`ifdef BIST_ADDR_COMPL_EN
            addr_d = addr_compl ? ~cnt_q : cnt_q;
`else
            addr_d = cnt_q;
`endif
        end
    end

    assign addr_out = addr_q;
    assign done     = done_q;
    assign busy     = (state_q == SWEEP);
    assign last     = (state_q == SWEEP) && at_final;

endmodule

// File: tb/tb_bist_addr_mux.sv
// tb_bist_addr_mux: directed and randomized checks of bist_addr_mux against a behavioural model.
// The bench builds with or without BIST_ADDR_COMPL_EN.
module tb_bist_addr_mux;

    localparam int unsigned ADDR_W = 6;
    localparam int MAXV = (1 << ADDR_W) - 1;

    logic              clk;
    logic              rst;
    logic              test_mode;
    logic [ADDR_W-1:0] func_addr;
    logic              start;
    logic              dir;
    logic              step;
    logic              addr_compl;
    logic [ADDR_W-1:0] addr_out;
    logic              busy;
    logic              last;
    logic              done;

    int checks = 0;
    int errors = 0;

    // Reference model state. m_cnt is the sweep position as an integer address.
    int m_cnt  = 0;
    bit m_busy = 0;
    bit m_dir  = 0;
    bit m_done = 0;
    int m_addr = 0;

    bist_addr_mux #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .test_mode (test_mode),
        .func_addr (func_addr),
        .start     (start),
        .dir       (dir),
        .step      (step),
`ifdef BIST_ADDR_COMPL_EN
        .addr_compl(addr_compl),
`endif
        .addr_out  (addr_out),
        .busy      (busy),
        .last      (last),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock. Update the model from the inputs sampled at the edge, then check all outputs.
    task automatic tick();
        int  final_addr;
        bit  use_compl;
        @(posedge clk);
        use_compl = 1'b0;
`ifdef BIST_ADDR_COMPL_EN
        use_compl = addr_compl;
`endif
        if (rst) begin
            m_addr = 0;
            m_cnt  = 0;
            m_busy = 0;
            m_dir  = 0;
            m_done = 0;
        end else begin
            if (test_mode) m_addr = use_compl ? (MAXV - m_cnt) : m_cnt;
            else           m_addr = int'(func_addr);
            m_done = 0;
            if (!m_busy) begin
                if (start) begin
                    m_cnt  = dir ? MAXV : 0;
                    m_dir  = dir;
                    m_busy = 1;
                end
            end else if (step) begin
                final_addr = m_dir ? 0 : MAXV;
                if (m_cnt == final_addr) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_cnt = m_dir ? m_cnt - 1 : m_cnt + 1;
                end
            end
        end
        #1;
        final_addr = m_dir ? 0 : MAXV;
        check("addr_out", 32'(addr_out), 32'(m_addr));
        check("busy", 32'(busy), 32'(m_busy));
        check("last", 32'(last), 32'(m_busy && (m_cnt == final_addr)));
        check("done", 32'(done), 32'(m_done));
    endtask

    task automatic idle_inputs();
        rst = 0; start = 0; step = 0; dir = 0;
    endtask

    initial begin
        int steps;
        int dones;
        int n;
        rst = 1; start = 1; step = 1; dir = 0; test_mode = 1;
        func_addr = '0; addr_compl = 0;

        // Reset dominates start and step.
        tick();
        tick();
        #1 idle_inputs(); step = 1;
        tick();
        tick();
        check("no_sweep_after_rst", 32'(busy), 32'(0));

        // Ascending sweep with step held high.
        #1 start = 1; dir = 0; step = 0;
        tick();
        #1 start = 0; step = 1;
        steps = 0; dones = 0; n = 0;
        while (!done && n < 200) begin
            if (busy) steps++;
            tick();
            n++;
        end
        check("asc_timeout", 32'(n < 200), 32'(1));
        check("asc_steps", 32'(steps), 32'(MAXV + 1));
        #1 step = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) dones++;
            tick();
        end
        check("asc_done_once", 32'(dones), 32'(1));
        check("asc_hold_top", 32'(addr_out), 32'(MAXV));

        // Descending sweep with step toggling.
        #1 start = 1; dir = 1;
        tick();
        #1 start = 0;
        steps = 0; n = 0;
        while (!done && n < 400) begin
            step = ~step;
            if (step && busy) steps++;
            tick();
            #1;
            n++;
        end
        check("desc_timeout", 32'(n < 400), 32'(1));
        check("desc_steps", 32'(steps), 32'(MAXV + 1));
        step = 0;
        tick();
        check("desc_hold_zero", 32'(addr_out), 32'(0));

        // Mode switch mid-sweep while start is ignored.
        #1 start = 1; dir = 0;
        tick();
        #1 start = 0; step = 1;
        n = 0;
        while (m_cnt != 20 && n < 100) begin tick(); #1; n++; end
        step = 0; test_mode = 0; func_addr = 6'h2A; start = 1; dir = 1;
        tick();
        check("func_select", 32'(addr_out), 32'h2A);
        #1 start = 0;
        tick();
        tick();
        #1 test_mode = 1;
        tick();
        tick();
        check("resume_cnt", 32'(addr_out), 32'd20);

        // Reset mid-sweep abandons the sweep with no done.
        #1 step = 1;
        while (m_cnt != 40 && n < 200) begin tick(); #1; n++; end
        rst = 1;
        tick();
        check("rst_mid_busy", 32'(busy), 32'(0));
        #1 rst = 0; step = 0;
        tick();
        check("rst_mid_cnt", 32'(addr_out), 32'(0));

        // Back-to-back: start during the done cycle.
        #1 start = 1; dir = 0;
        tick();
        #1 start = 0; step = 1; n = 0;
        while (!done && n < 200) begin tick(); n++; end
        #1 start = 1; dir = 1; step = 0;
        tick();
        check("b2b_busy", 32'(busy), 32'(1));
        #1 start = 0;
        tick();
        check("b2b_top", 32'(addr_out), 32'(MAXV));

`ifdef BIST_ADDR_COMPL_EN
        // Complemented ascending sweep.
        #1 rst = 1;
        tick();
        #1 rst = 0; addr_compl = 1; start = 1; dir = 0;
        tick();
        #1 start = 0; step = 1; n = 0;
        while (!done && n < 200) begin tick(); n++; end
        check("compl_end", 32'(addr_out), 32'(0));
        #1 test_mode = 0; func_addr = 6'h15; step = 0;
        tick();
        check("compl_func", 32'(addr_out), 32'h15);
        #1 test_mode = 1; addr_compl = 0;
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            #1;
            rst        = ($urandom_range(0, 63) == 0);
            start      = ($urandom_range(0, 7) == 0);
            dir        = 1'($urandom);
            step       = 1'($urandom);
            test_mode  = ($urandom_range(0, 3) != 0);
            func_addr  = ADDR_W'($urandom);
            addr_compl = 1'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bist_addr_mux.md
# bist_addr_mux

Parametrised, registered address source for the SRAM BIST path. Combines an up/down BIST address sweep counter with the functional/test address select, so the SRAM address port sees one registered address bus. Sits between the BIST controller (start/step/done handshake) and the SRAM macro address pins, in place of the plain combinational address select.

## Interface

Parameters:
- ADDR_W, default 6: address width. Sweep range is 0 to 2^ADDR_W-1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- test_mode, input, 1: 0 selects func_addr, 1 selects the BIST counter.
- func_addr, input, ADDR_W: functional (mission-mode) address.
- start, input, 1: one-cycle request to begin a sweep. Honoured only in IDLE.
- dir, input, 1: sweep direction, sampled with start. 0 = ascending, 1 = descending.
- step, input, 1: advance the counter by one address. Honoured only in SWEEP.
- addr_out, output, ADDR_W: registered selected address to the SRAM.
- busy, output, 1: high while in SWEEP.
- last, output, 1: high in SWEEP when the counter holds the final address of the sweep.
- done, output, 1: one-cycle pulse when a sweep completes.

## Operation

- Internal state: FSM {IDLE, SWEEP}, counter cnt[ADDR_W-1:0], latched direction dir_q.
- IDLE:
  - cnt holds.
  - start=1 loads cnt with 0 (dir=0) or 2^ADDR_W-1 (dir=1), latches dir_q, and moves to SWEEP.
  - step is ignored.
- SWEEP:
  - step=1 with cnt not final: cnt increments (dir_q=0) or decrements (dir_q=1).
  - step=1 with cnt final (2^ADDR_W-1 ascending, 0 descending): cnt holds, the FSM returns to IDLE, and done pulses.
  - step=0: cnt holds.
  - start is ignored; a sweep cannot be restarted mid-flight without rst.
- There is no wrap-around. The counter never passes its final address.
- Output select, every cycle regardless of state: addr_out <= test_mode ? cnt : func_addr.
- test_mode is independent of the FSM. Dropping test_mode mid-sweep switches addr_out to func_addr while the sweep state and cnt are preserved.
- busy = (state == SWEEP).
- last = busy && (cnt == final address for dir_q).
- Both busy and last are combinational from registers (no input-to-output path).

## Timing

- Reset: in the cycle after rst is sampled high, state=IDLE, cnt=0, dir_q=0, addr_out=0, busy=0, last=0, done=0. rst takes priority over start and step, including mid-sweep; the sweep is abandoned without a done pulse.
- addr_out latency: 1 cycle. addr_out(t+1) = test_mode(t) ? cnt(t) : func_addr(t). A counter value therefore appears on addr_out one cycle after it is loaded or updated.
- start sampled at edge t:
  - busy=1 and cnt=start address from t+1.
  - That address appears on addr_out at t+2 when test_mode=1.
- Final step sampled at edge t: done=1 and busy=0 during cycle t+1 only; done=0 again at t+2.
- start in the same cycle as the done pulse is accepted, since the FSM is already in IDLE.
- ADDR_W=1: start address equals final address ±1. The sweep needs exactly 2 steps (the final step included) after start. For any width, a sweep takes 2^ADDR_W steps.

## Configuration

- Macro: BIST_ADDR_COMPL_EN.
- Defined:
  - Adds input port addr_compl (1 bit).
  - When test_mode=1 and addr_compl=1, addr_out <= ~cnt (bitwise, ADDR_W bits), for address-complement march elements.
  - Complement applies only to the output. cnt, last and done behaviour are unchanged.
  - addr_compl has no effect when test_mode=0.
- Not defined: the port does not exist and addr_out is always cnt in test mode.

## Test plan

- Reset: ADDR_W=6; drive start=1, step=1, test_mode=1 with rst=1 for 2 cycles -> addr_out=0, busy=0, last=0, done=0, and no sweep started after rst deasserts.
- Ascending sweep: test_mode=1, start with dir=0, then step held high -> addr_out sequence 0,1,…,63 (each 1 cycle after cnt), last=1 while cnt=63, done pulses once for exactly 1 cycle, busy falls with done, addr_out stays 63.
- Descending sweep with gaps: dir=1, step toggled 1/0 -> addr_out 63,63,62,62,…,0, done only after the step sampled at cnt=0, 64 steps total.
- Mode switch mid-sweep: sweep at cnt=20, test_mode=0 with func_addr=6'h2A for 3 cycles, then test_mode=1 -> addr_out=0x2A one cycle after the switch, then resumes at 20 (or later if step was asserted); start during SWEEP has no effect.
- Reset mid-sweep and back-to-back: rst at cnt=40 -> IDLE, cnt=0, no done. Separately, start asserted in the done cycle -> a new sweep begins and busy stays high 1 cycle after done.
- BIST_ADDR_COMPL_EN defined: ascending sweep with addr_compl=1 -> addr_out 63,62,…,0 while last and done match the uncomplemented sweep; with test_mode=0, addr_out = func_addr.
